// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_controller
// Purpose  : Data-memory back end. Splits each 32-bit load/store into two
//            16-bit accesses on an external asynchronous SRAM and holds the
//            pipeline (ready=0) until the access completes.
// Options  : SRAM_POSTED_WRITE_EN - when defined, writes release the pipeline
//            in the request cycle and skip DONE; reads still block.
// Revision : 1.0 - initial release
// ============================================================================
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

`ifdef SRAM_POSTED_WRITE_EN
    localparam bit c_posted = 1'b1;
`else
    localparam bit c_posted = 1'b0;
`endif

    localparam logic [31:0] c_base     = 32'(BASE_ADDR);
    localparam logic [3:0]  c_cnt_last = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_LO = 2'd1,
        ST_ACC_HI = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                   r_state;
    logic [3:0]               r_cnt;
    logic                     r_is_wr;
    logic [SRAM_ADDR_W-2:0]   r_wa;
    logic [31:0]              r_wdata;
    logic [31:0]              r_read_data;
    logic [SRAM_ADDR_W-1:0]   r_addr;
    logic                     r_ce_n;
    logic                     r_oe_n;
    logic                     r_we_n;
    logic                     r_dq_oe;
    logic [15:0]              r_dq_out;

    logic                     w_req;
    logic                     w_ready;
    logic [31:0]              w_diff;
    logic [SRAM_ADDR_W-2:0]   w_wa;
    logic                     w_unused_diff_bits;

    // Word address relative to the SRAM window; out-of-range addresses wrap.
    assign w_diff             = address - c_base;
    assign w_wa               = w_diff[SRAM_ADDR_W:2];
    assign w_unused_diff_bits = ^{w_diff[31:SRAM_ADDR_W+1], w_diff[1:0]};
    assign w_req              = rd_en | wr_en;

    // Pipeline release: free in IDLE without a request (or on a posted write), and in DONE.
    always_comb begin
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = !w_req || (c_posted && wr_en);
            ST_DONE: w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    // Access sequencer; SRAM strobes are registered so they change cleanly on clock edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_is_wr     <= 1'b0;
            r_wa        <= '0;
            r_wdata     <= 32'd0;
            r_read_data <= 32'd0;
            r_addr      <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        // A simultaneous rd_en/wr_en is a store.
                        r_is_wr  <= wr_en;
                        r_wa     <= w_wa;
                        r_wdata  <= write_data;
                        r_cnt    <= 4'd0;
                        r_addr   <= {w_wa, 1'b0};
                        r_ce_n   <= 1'b0;
                        r_oe_n   <= wr_en;
                        r_we_n   <= 1'b1;
                        r_dq_oe  <= wr_en;
                        r_dq_out <= write_data[15:0];
                        r_state  <= ST_ACC_LO;
                    end
                end
                ST_ACC_LO: begin
                    if (r_cnt == c_cnt_last) begin
                        if (!r_is_wr) begin
                            r_read_data[15:0] <= sram_dq;
                        end
                        r_cnt    <= 4'd0;
                        r_addr   <= {r_wa, 1'b1};
                        r_we_n   <= 1'b1;
                        r_dq_out <= r_wdata[31:16];
                        r_state  <= ST_ACC_HI;
                    end else begin
                        // First phase cycle is address setup; the write strobe follows.
                        r_cnt  <= r_cnt + 4'd1;
                        r_we_n <= ~r_is_wr;
                    end
                end
                ST_ACC_HI: begin
                    if (r_cnt == c_cnt_last) begin
                        if (!r_is_wr) begin
                            r_read_data[31:16] <= sram_dq;
                        end
                        r_cnt   <= 4'd0;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_state <= (c_posted && r_is_wr) ? ST_IDLE : ST_DONE;
                    end else begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_we_n <= ~r_is_wr;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready     = w_ready;
    assign read_data = r_read_data;
    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_ub_n = r_ce_n;
    assign sram_lb_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_dq   = r_dq_oe ? r_dq_out : 16'bz;

endmodule
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_controller
// Purpose  : Self-checking bench for sram_controller with an asynchronous
//            SRAM model and a transaction-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int W = 5;
`ifdef SRAM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    sram_controller #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .sram_dq(sram_dq), .sram_addr(sram_addr),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Physical asynchronous SRAM: drives on read, captures mid-cycle while written.
    logic [15:0] sram [0:262143];
    int we_lo_cnt = 0;
    int we_hi_cnt = 0;
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram[sram_addr] : 16'bz;
    always @(negedge clk) begin
        if (rst && !sram_ce_n && !sram_we_n) begin
            sram[sram_addr] = sram_dq;
            if (sram_addr[0]) we_hi_cnt++;
            else              we_lo_cnt++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: word-level memory plus the timeline of the current op.
    logic [31:0] ref_mem [0:131071];
    int          m_acc  = -100;
    int          m_end  = 0;
    int          m_done = -1;
    bit          m_wr   = 1'b0;
    int          m_wa   = 0;
    logic [31:0] m_wd   = 32'd0;
    logic [31:0] m_pend = 32'd0;
    logic [31:0] m_rd   = 32'd0;

    task automatic chk_idle_strobes(input string nm);
        chk({nm, "_ce"}, 32'(sram_ce_n), 32'd1);
        chk({nm, "_oe"}, 32'(sram_oe_n), 32'd1);
        chk({nm, "_we"}, 32'(sram_we_n), 32'd1);
        chk({nm, "_bytes"}, 32'({sram_ub_n, sram_lb_n}), 32'd3);
    endtask

    // Compare process: every cycle, outputs against the model's expectation.
    always @(negedge clk) begin
        int  p;
        bit  exp_rdy;
        if (!rst) begin
            m_end  = cyc;
            m_done = -1;
            m_rd   = 32'd0;
            chk("rst_ready", 32'(ready), 32'(!(rd_en | wr_en) || (POSTED && wr_en)));
            chk("rst_read_data", read_data, 32'd0);
            chk("rst_addr", 32'(sram_addr), 32'd0);
            chk_idle_strobes("rst");
        end else if (cyc < m_end) begin
            if (cyc == m_done) begin
                if (!m_wr) m_rd = m_pend;
                chk("done_ready", 32'(ready), 32'd1);
                chk("done_read_data", read_data, m_rd);
                chk_idle_strobes("done");
            end else begin
                p = cyc - m_acc - 1;
                chk("busy_ready", 32'(ready), 32'd0);
                chk("busy_ce", 32'(sram_ce_n), 32'd0);
                chk("busy_bytes", 32'({sram_ub_n, sram_lb_n}), 32'd0);
                chk("busy_addr", 32'(sram_addr), 32'((m_wa << 1) | ((p >= W) ? 1 : 0)));
                chk("busy_oe", 32'(sram_oe_n), 32'(m_wr));
                chk("busy_we", 32'(sram_we_n), 32'((m_wr && (p % W) != 0) ? 0 : 1));
                if (m_wr)
                    chk("busy_dq", 32'(sram_dq), 32'((p < W) ? m_wd[15:0] : m_wd[31:16]));
            end
        end else begin
            exp_rdy = !(rd_en | wr_en) || (POSTED && wr_en);
            chk("idle_ready", 32'(ready), 32'(exp_rdy));
            if (exp_rdy) chk("idle_read_data", read_data, m_rd);
            chk_idle_strobes("idle");
            if (rd_en | wr_en) begin
                m_acc = cyc;
                m_wr  = wr_en;
                m_wa  = int'(((address - 32'd1024) >> 2) & 32'h1FFFF);
                m_wd  = write_data;
                if (m_wr) ref_mem[m_wa] = write_data;
                else      m_pend = ref_mem[m_wa];
                if (POSTED && m_wr) begin
                    m_end  = cyc + 2 * W + 1;
                    m_done = -1;
                end else begin
                    m_end  = cyc + 2 * W + 2;
                    m_done = cyc + 2 * W + 1;
                end
            end
        end
    end

    // One request, held until ready; optionally perturbs inputs mid-access.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input bit mut, output int stall);
        @(posedge clk); #1;
        rd_en = rd; wr_en = wr; address = a; write_data = d;
        stall = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) break;
            stall++;
            if (mut && stall == 3) begin
                address    = 32'd1040;
                write_data = 32'h11112222;
            end
        end
        if (stall >= 200) chk("op_timeout", 32'(stall), 32'd11);
        @(posedge clk); #1;
        rd_en = 1'b0; wr_en = 1'b0;
    endtask

    int st;
    int wr_stall;

    initial begin
        wr_stall   = POSTED ? 0 : 11;
        rst        = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_ready", 32'(ready), 32'd1);
        chk("init_read_data", read_data, 32'd0);
        rst = 1'b1;

        // Store 0xDEADBEEF at 1028 -> halfwords 2 and 3.
        we_lo_cnt = 0; we_hi_cnt = 0;
        do_op(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, st);
        chk("t2_stall", 32'(st), 32'(wr_stall));
        repeat (12) @(posedge clk);
        chk("t2_mem2", 32'(sram[2]), 32'h0000BEEF);
        chk("t2_mem3", 32'(sram[3]), 32'h0000DEAD);
        chk("t2_we_lo", 32'(we_lo_cnt), 32'd4);
        chk("t2_we_hi", 32'(we_hi_cnt), 32'd4);

        // Load it back; no write strobes.
        we_lo_cnt = 0; we_hi_cnt = 0;
        do_op(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, st);
        chk("t3_stall", 32'(st), 32'd11);
        chk("t3_read_data", read_data, 32'hDEADBEEF);
        chk("t3_no_we", 32'(we_lo_cnt + we_hi_cnt), 32'd0);

        // Both enables: store.
        do_op(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, st);
        chk("t4_stall", 32'(st), 32'(wr_stall));
        repeat (12) @(posedge clk);
        chk("t4_mem4", 32'(sram[4]), 32'h00005678);
        chk("t4_mem5", 32'(sram[5]), 32'h00001234);
        chk("t4_read_data", read_data, 32'hDEADBEEF);

        // Reset in the middle of ACC_HI of a store to 1100 (halfwords 38/39).
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1100; write_data = 32'hA5A55A5A;
        repeat (8) @(posedge clk);
        #1;
        chk("t1_in_hi_addr", 32'(sram_addr), 32'd39);
        chk("t1_in_hi_we", 32'(sram_we_n), 32'd0);
        rst = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("t1_rst_we", 32'(sram_we_n), 32'd1);
        chk("t1_rst_ce", 32'(sram_ce_n), 32'd1);
        chk("t1_rst_read_data", read_data, 32'd0);
        chk("t1_rst_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t1_after_ready", 32'(ready), 32'd1);
        chk("t1_after_oe", 32'(sram_oe_n), 32'd1);

        // Wrapping store with inputs disturbed mid-access, then read it back.
        do_op(1'b0, 1'b1, 32'd1024 + 32'h80000, 32'hCAFEF00D, 1'b1, st);
        repeat (12) @(posedge clk);
        chk("t5_mem0", 32'(sram[0]), 32'h0000F00D);
        chk("t5_mem1", 32'(sram[1]), 32'h0000CAFE);
        do_op(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, st);
        chk("t5_read_wrap", read_data, 32'hCAFEF00D);

`ifdef SRAM_POSTED_WRITE_EN
        // Posted store then an immediate load of the same word.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1036; write_data = 32'h0BADF00D;
        @(negedge clk);
        chk("t6_posted_ready", 32'(ready), 32'd1);
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b1;
        st = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ready) break;
            st++;
        end
        chk("t6_stall", 32'(st), 32'd21);
        @(posedge clk); #1;
        rd_en = 1'b0;
        chk("t6_read_data", read_data, 32'h0BADF00D);
`endif

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
